xlr8_clkout: RTL and testbench



---
 rtl/xlr8_clkout_pkg.sv | 11 +
 rtl/xlr8_clkout_if.sv | 15 +
 rtl/xlr8_clkout_gen.sv | 65 ++++++
 rtl/xlr8_clkout.sv | 73 +++++++
 tb/tb_xlr8_clkout.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xlr8_clkout_pkg.sv
// xlr8_clkout_pkg: state type, widths, CLKODR bit positions and address-space helper
package xlr8_clkout_pkg;
    localparam int DIVEXP_W = 4;
    localparam int CNT_W = 16;
    localparam int ODR_DIVEXP_LSB = 0;
    localparam int ODR_RUN_BIT = 7;
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    function automatic logic is_dm(input logic [7:0] addr);
        return addr >= 8'h60;
    endfunction
endpackage

// File: rtl/xlr8_clkout_if.sv
// xlr8_clkout_if: AVR I/O and data-memory register bus
interface xlr8_clkout_if;
    logic [5:0] adr;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic iore;
    logic iowe;
    logic io_out_en;
    logic [7:0] ramadr;
    logic ramre;
    logic ramwe;
    logic dm_sel;
    modport master(output adr, dbus_in, iore, iowe, ramadr, ramre, ramwe, dm_sel, input dbus_out, io_out_en);
    modport slave(input adr, dbus_in, iore, iowe, ramadr, ramre, ramwe, dm_sel, output dbus_out, io_out_en);
endinterface

// File: rtl/xlr8_clkout_gen.sv
// xlr8_clkout_gen: half-period counter, shadow DIVEXP and glitch-free run/stop FSM (rise port with XLR8_CLKOUT_CNT_EN)
module xlr8_clkout_gen
    import xlr8_clkout_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                clken,
    input  logic                en_q,
    input  logic [DIVEXP_W-1:0] divexp,
`ifdef XLR8_CLKOUT_CNT_EN
    output logic                rise,
`endif
    output logic                clkout,
    output logic                clkout_oe
);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [DIVEXP_W-1:0] divexp_act;
    logic clkout_nx, load, term;

    assign term = cnt == (CNT_W'(1) << divexp_act) - CNT_W'(1);
`ifdef XLR8_CLKOUT_CNT_EN
    assign rise = clkout_nx && !clkout;
`endif

    // STOP only exists while clkout is high, so a low phase can be abandoned at once
    always_comb begin
        state_nx = state;
        cnt_nx = cnt + CNT_W'(1);
        clkout_nx = clkout;
        load = 1'b0;
        if (state == IDLE) begin
            cnt_nx = '0;
            if (en_q) begin
                state_nx = RUN;
                clkout_nx = 1'b1;
                load = 1'b1;
            end
        end else if (!en_q && !clkout) begin
            state_nx = IDLE;
            cnt_nx = '0;
        end else if (term) begin
            state_nx = en_q ? RUN : IDLE;
            clkout_nx = !clkout;
            cnt_nx = '0;
            load = 1'b1;
        end else
            state_nx = en_q ? RUN : STOP;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            clkout <= 1'b0;
            clkout_oe <= 1'b0;
            divexp_act <= '0;
        end else if (clken) begin
            state <= state_nx;
            cnt <= cnt_nx;
            clkout <= clkout_nx;
            clkout_oe <= state_nx != IDLE;
            if (load) divexp_act <= divexp;
        end
endmodule

// File: rtl/xlr8_clkout.sv
// xlr8_clkout: divided clock output with CLKODR register; XLR8_CLKOUT_CNT_EN adds the CLKOCNT rising-edge counter
module xlr8_clkout
    import xlr8_clkout_pkg::*;
#(
    parameter logic [7:0]          CLKODR_ADDR  = 8'hE6,
    parameter logic [7:0]          CLKOCNT_ADDR = 8'hE7,
    parameter logic [DIVEXP_W-1:0] DIVEXP_RESET = 4'd9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clken,
    xlr8_clkout_if.slave bus,
    input  logic         intosc_div1024_en,
    output logic         clkout,
    output logic         clkout_oe
);
    localparam bit ODR_DM = is_dm(CLKODR_ADDR);
    logic en_q, odr_sel, odr_re, odr_we, cnt_re;
    logic [DIVEXP_W-1:0] divexp;
    logic [7:0] odr_val, cnt_val;

    assign odr_sel = ODR_DM ? bus.dm_sel && bus.ramadr == CLKODR_ADDR : bus.adr == CLKODR_ADDR[5:0];
    assign odr_re = odr_sel && (ODR_DM ? bus.ramre : bus.iore);
    assign odr_we = odr_sel && (ODR_DM ? bus.ramwe : bus.iowe);

    always_comb begin
        odr_val = '0;
        odr_val[ODR_DIVEXP_LSB +: DIVEXP_W] = divexp;
        odr_val[ODR_RUN_BIT] = clkout_oe;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            en_q <= 1'b0;
            divexp <= DIVEXP_RESET;
        end else if (clken) begin
            en_q <= intosc_div1024_en;
            if (odr_we) divexp <= bus.dbus_in[ODR_DIVEXP_LSB +: DIVEXP_W];
        end

`ifdef XLR8_CLKOUT_CNT_EN
    localparam bit CNT_DM = is_dm(CLKOCNT_ADDR);
    logic cnt_sel, cnt_we, rise;

    assign cnt_sel = CNT_DM ? bus.dm_sel && bus.ramadr == CLKOCNT_ADDR : bus.adr == CLKOCNT_ADDR[5:0];
    assign cnt_re = cnt_sel && (CNT_DM ? bus.ramre : bus.iore);
    assign cnt_we = cnt_sel && (CNT_DM ? bus.ramwe : bus.iowe);

    // a clearing write beats a coincident rising edge
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_val <= '0;
        else if (clken) cnt_val <= cnt_we ? 8'd0 : cnt_val + 8'(rise);
`else
    assign cnt_re = 1'b0;
    assign cnt_val = '0;
`endif

    xlr8_clkout_gen u_gen (
        .clk,
        .rstn,
        .clken,
        .en_q,
        .divexp,
`ifdef XLR8_CLKOUT_CNT_EN
        .rise,
`endif
        .clkout,
        .clkout_oe
    );

    assign bus.io_out_en = odr_re || cnt_re;
    assign bus.dbus_out = odr_re ? odr_val : cnt_re ? cnt_val : 8'd0;
endmodule

// File: tb/tb_xlr8_clkout.sv
// tb_xlr8_clkout: randomized self-checking bench; phase lengths and register values come from a model of the divide rules
module tb_xlr8_clkout;
    localparam logic [7:0] ODR = 8'hE6;
    localparam logic [7:0] CNT = 8'hE7;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clken = 1'b1;
    logic en = 1'b0;
    logic clkout, clkout_oe;
    int passed = 0;
    int total = 0;
    int m_divexp = 9;

    xlr8_clkout_if bus();
    xlr8_clkout dut (
        .clk(clk),
        .rstn(rstn),
        .clken(clken),
        .bus(bus),
        .intosc_div1024_en(en),
        .clkout(clkout),
        .clkout_oe(clkout_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic int half(input int d);
        return 1 << d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus.ramadr = a;
        bus.dbus_in = d;
        bus.dm_sel = 1'b1;
        bus.ramwe = 1'b1;
        if (clken && a == ODR) m_divexp = int'(d[3:0]);
        tick();
        bus.ramwe = 1'b0;
        bus.dm_sel = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic v);
        bus.ramadr = a;
        bus.dm_sel = 1'b1;
        bus.ramre = 1'b1;
        #1;
        d = bus.dbus_out;
        v = bus.io_out_en;
        bus.ramre = 1'b0;
        bus.dm_sel = 1'b0;
        #1;
    endtask

    task automatic wait_for(input logic v, input int max, output int n);
        n = 0;
        while (clkout !== v && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic v;
        int n;
        bus.adr = '0;
        bus.dbus_in = '0;
        bus.iore = 1'b0;
        bus.iowe = 1'b0;
        bus.ramadr = '0;
        bus.ramre = 1'b0;
        bus.ramwe = 1'b0;
        bus.dm_sel = 1'b0;
        rstn = 1'b0;
        m_divexp = 9;
        repeat (3) tick();
        total++; if (clkout !== 1'b0 || clkout_oe !== 1'b0) $display("FAIL reset_out: clkout=%b oe=%b expected 0 0", clkout, clkout_oe); else passed++;
        total++; if (bus.dbus_out !== 8'h00 || bus.io_out_en !== 1'b0) $display("FAIL reset_bus: dbus_out=%h io_out_en=%b expected 00 0", bus.dbus_out, bus.io_out_en); else passed++;
        rstn = 1'b1;
        repeat (2) tick();
        bus_read(ODR, d, v);
        total++; if (d !== 8'h09 || v !== 1'b1) $display("FAIL reset_odr: got %h/%b expected 09/1", d, v); else passed++;
        en = 1'b1;
        tick();
        total++; if (clkout !== 1'b0) $display("FAIL start_early: clkout=%b expected 0", clkout); else passed++;
        tick();
        total++; if (clkout !== 1'b1 || clkout_oe !== 1'b1) $display("FAIL start_rise: clkout=%b oe=%b expected 1 1", clkout, clkout_oe); else passed++;
        wait_for(1'b0, 70000, n);
        total++; if (n !== half(m_divexp)) $display("FAIL default_high: got %0d expected %0d", n, half(m_divexp)); else passed++;
        wait_for(1'b1, 70000, n);
        total++; if (n !== half(m_divexp)) $display("FAIL default_low: got %0d expected %0d", n, half(m_divexp)); else passed++;
    endtask

    task automatic test_ratio_change();
        logic [7:0] d;
        logic v;
        int n;
        repeat (100) tick();
        bus_write(ODR, 8'h00);
        wait_for(1'b0, 70000, n);
        total++; if (101 + n !== 512) $display("FAIL ratio_high_kept: got %0d expected 512", 101 + n); else passed++;
        wait_for(1'b1, 10, n);
        total++; if (n !== half(m_divexp)) $display("FAIL ratio_low_new: got %0d expected %0d", n, half(m_divexp)); else passed++;
        wait_for(1'b0, 10, n);
        total++; if (n !== half(m_divexp)) $display("FAIL ratio_high_new: got %0d expected %0d", n, half(m_divexp)); else passed++;
        bus_read(ODR, d, v);
        total++; if (d !== 8'h80) $display("FAIL ratio_odr: got %h expected 80", d); else passed++;
    endtask

    task automatic test_drop_high();
        int n;
        bus_write(ODR, 8'h02);
        wait_for(!clkout, 100, n);
        if (clkout) wait_for(1'b0, 100, n);
        wait_for(1'b1, 100, n);
        en = 1'b0;
        wait_for(1'b0, 20, n);
        total++; if (n !== half(m_divexp)) $display("FAIL drop_high_len: got %0d expected %0d", n, half(m_divexp)); else passed++;
        total++; if (clkout_oe !== 1'b0) $display("FAIL drop_oe: got %b expected 0", clkout_oe); else passed++;
        repeat (5) tick();
        total++; if (clkout !== 1'b0 || clkout_oe !== 1'b0) $display("FAIL drop_idle: clkout=%b oe=%b expected 0 0", clkout, clkout_oe); else passed++;
        en = 1'b1;
        wait_for(1'b1, 10, n);
        tick();
        en = 1'b0;
        tick();
        en = 1'b1;
        wait_for(1'b0, 20, n);
        total++; if (n + 2 !== half(m_divexp)) $display("FAIL stop_resume_high: got %0d expected %0d", n + 2, half(m_divexp)); else passed++;
        total++; if (clkout_oe !== 1'b1) $display("FAIL stop_resume_oe: got %b expected 1", clkout_oe); else passed++;
        wait_for(1'b1, 20, n);
        total++; if (n !== half(m_divexp)) $display("FAIL stop_resume_low: got %0d expected %0d", n, half(m_divexp)); else passed++;
    endtask

    task automatic test_freeze();
        logic [7:0] d;
        logic v;
        int n;
        wait_for(1'b0, 20, n);
        wait_for(1'b1, 20, n);
        tick();
        clken = 1'b0;
        repeat (9) tick();
        bus_write(ODR, 8'h05);
        clken = 1'b1;
        wait_for(1'b0, 40, n);
        total++; if (11 + n !== half(m_divexp) + 10) $display("FAIL freeze_len: got %0d expected %0d", 11 + n, half(m_divexp) + 10); else passed++;
        bus_read(ODR, d, v);
        total++; if (d !== (8'(m_divexp) | 8'h80)) $display("FAIL freeze_odr: got %h expected %h", d, 8'(m_divexp) | 8'h80); else passed++;
    endtask

    task automatic test_random_ratio();
        logic [7:0] d;
        logic v;
        int n;
        for (int i = 0; i < 6; i++) begin
            bus_write(ODR, 8'($urandom_range(0, 6)));
            wait_for(!clkout, 200, n);
            wait_for(!clkout, 200, n);
            total++; if (n !== half(m_divexp)) $display("FAIL rand_phase_a[%0d]: got %0d expected %0d", i, n, half(m_divexp)); else passed++;
            wait_for(!clkout, 200, n);
            total++; if (n !== half(m_divexp)) $display("FAIL rand_phase_b[%0d]: got %0d expected %0d", i, n, half(m_divexp)); else passed++;
            bus_read(ODR, d, v);
            total++; if (d !== (8'(m_divexp) | 8'h80) || v !== 1'b1) $display("FAIL rand_odr[%0d]: got %h/%b expected %h/1", i, d, v, 8'(m_divexp) | 8'h80); else passed++;
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        logic v;
        int n;
        wait_for(1'b0, 200, n);
        wait_for(1'b1, 200, n);
        repeat (2) tick();
        #2;
        rstn = 1'b0;
        m_divexp = 9;
        #1;
        total++; if (clkout !== 1'b0 || clkout_oe !== 1'b0) $display("FAIL midreset_out: clkout=%b oe=%b expected 0 0", clkout, clkout_oe); else passed++;
        bus_read(ODR, d, v);
        total++; if (d !== 8'(m_divexp)) $display("FAIL midreset_odr: got %h expected %h", d, 8'(m_divexp)); else passed++;
        rstn = 1'b1;
        wait_for(1'b1, 10, n);
        total++; if (n !== 2) $display("FAIL midreset_restart: got %0d expected 2", n); else passed++;
        wait_for(1'b0, 70000, n);
        total++; if (n !== half(m_divexp)) $display("FAIL midreset_high: got %0d expected %0d", n, half(m_divexp)); else passed++;
    endtask

    task automatic test_edge_counter();
        logic [7:0] d;
        logic v;
`ifdef XLR8_CLKOUT_CNT_EN
        int n;
        int rises;
        logic prev;
        en = 1'b0;
        n = 0;
        while (clkout_oe !== 1'b0 && n < 70000) begin
            tick();
            n++;
        end
        bus_write(ODR, 8'h00);
        bus_write(CNT, 8'h5A);
        en = 1'b1;
        rises = 0;
        prev = clkout;
        n = 0;
        while (rises < 300 && n < 2000) begin
            tick();
            n++;
            if (clkout && !prev) rises++;
            prev = clkout;
        end
        en = 1'b0;
        n = 0;
        while (clkout_oe !== 1'b0 && n < 20) begin
            tick();
            n++;
            if (clkout && !prev) rises++;
            prev = clkout;
        end
        total++; if (rises < 300) $display("FAIL cnt_budget: saw %0d rises expected at least 300", rises); else passed++;
        bus_read(CNT, d, v);
        total++; if (d !== 8'(rises % 256) || v !== 1'b1) $display("FAIL cnt_value: got %0d/%b expected %0d/1", d, v, rises % 256); else passed++;
        bus_write(CNT, 8'($urandom));
        bus_read(CNT, d, v);
        total++; if (d !== 8'h00) $display("FAIL cnt_clear: got %0d expected 0", d); else passed++;
`else
        bus_read(CNT, d, v);
        total++; if (v !== 1'b0 || d !== 8'h00) $display("FAIL cnt_absent: got %h/%b expected 00/0", d, v); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_ratio_change();
        test_drop_high();
        test_freeze();
        test_random_ratio();
        test_reset_mid_run();
        test_edge_counter();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
